// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I memory stage; ports: CLK/RST, EX inputs (ex_valid, op, funct3, AluOutput, ReadData2, RegWr, rd), data-memory port (mem_*), stall, registered write-back (wb_*).
module mem_access_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [31:0] AluOutput,
  input  logic [31:0] ReadData2,
  input  logic        RegWr,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWr,
  output logic [1:0]  wb_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic [4:0] rd_q;
  logic regwr_q;
  logic [31:0] alu_q;
  logic is_ld, is_st, is_mem, illegal, misal, hit_to;
  logic [3:0] wstrb_n;
  logic [31:0] wdata_n, ld_data;
  logic [7:0] byte_s;
  logic [15:0] half_s;
  always_comb begin
    is_ld = op == 7'b0000011;
    is_st = op == 7'b0100011;
    is_mem = is_ld | is_st;
    illegal = is_ld ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : (funct3[2] | (funct3[1] & funct3[0]));
    misal = (funct3[1:0] == 2'b01 && AluOutput[0]) || (funct3[1:0] == 2'b10 && AluOutput[1:0] != 2'b00);
    hit_to = cnt == TO;
    stall = state == WAIT && !mem_ready && !hit_to;
    state_n = state == IDLE ? ((ex_valid && is_mem && !illegal && !misal) ? WAIT : IDLE)
                            : ((mem_ready || hit_to) ? IDLE : WAIT);
    wstrb_n = funct3[1:0] == 2'b00 ? 4'b0001 << AluOutput[1:0] :
              funct3[1:0] == 2'b01 ? (AluOutput[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = funct3[1:0] == 2'b00 ? {4{ReadData2[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{ReadData2[15:0]}} : ReadData2;
    byte_s = 8'(mem_rdata >> {a_q, 3'b000});
    half_s = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] set selects the unsigned variants (lbu/lhu)
    ld_data = f3_q[1] ? mem_rdata :
              f3_q[0] ? {{16{~f3_q[2] & half_s[15]}}, half_s} : {{24{~f3_q[2] & byte_s[7]}}, byte_s};
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_RegWr <= 1'b0;
      wb_err <= '0;
      f3_q <= '0;
      a_q <= '0;
      rd_q <= '0;
      regwr_q <= 1'b0;
      alu_q <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && (!is_mem || illegal || misal)) begin
          wb_valid <= 1'b1;
          wb_data <= AluOutput;
          wb_rd <= rd;
          wb_RegWr <= RegWr & ~is_mem;
          wb_err <= !is_mem ? 2'b00 : illegal ? 2'b11 : 2'b01;
        end else if (ex_valid) begin
          mem_req <= 1'b1;
          mem_we <= is_st;
          mem_addr <= {AluOutput[31:2], 2'b00};
          mem_wstrb <= is_st ? wstrb_n : 4'b0000;
          mem_wdata <= is_st ? wdata_n : 32'h0;
          f3_q <= funct3;
          a_q <= AluOutput[1:0];
          rd_q <= rd;
          regwr_q <= RegWr;
          alu_q <= AluOutput;
          cnt <= '0;
        end
      end else if (mem_ready) begin
        mem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_data <= mem_we ? alu_q : ld_data;
        wb_rd <= rd_q;
        wb_RegWr <= regwr_q & ~mem_we;
        wb_err <= 2'b00;
      end else if (hit_to) begin
        mem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_data <= alu_q;
        wb_rd <= rd_q;
        wb_err <= 2'b10;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  logic CLK = 0, RST = 1, ex_valid = 0, RegWr = 0, mem_ready = 0;
  logic [6:0] op = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] AluOutput = 0, ReadData2 = 0, mem_rdata = 0;
  logic [4:0] rd = 0;
  logic mem_req, mem_we, stall, wb_valid, wb_RegWr;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0] mem_wstrb;
  logic [4:0] wb_rd;
  logic [1:0] wb_err;
  int errs = 0, checks = 0;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011;
  mem_access_unit dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .op(op), .funct3(funct3),
    .AluOutput(AluOutput), .ReadData2(ReadData2), .RegWr(RegWr), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .wb_err(wb_err)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1; op = o; funct3 = f; AluOutput = a; ReadData2 = d; RegWr = 1; rd = 5'd9;
    @(negedge CLK);
  endtask
  task automatic mem_op(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input int k, input logic [31:0] rdata, input logic [3:0] strb, input logic [31:0] wd);
    issue(o, f, a, d);
    op = ALU; AluOutput = 32'hFFFF_FFFF; ReadData2 = 32'h0;
    for (int i = 0; i < k; i++) begin
      check("wait_stall", stall, 1);
      check("wait_wb_valid", wb_valid, 0);
      @(negedge CLK);
    end
    check("mem_req", mem_req, 1);
    check("mem_addr", mem_addr, {a[31:2], 2'b00});
    check("mem_we", mem_we, o == ST);
    check("mem_wstrb", mem_wstrb, strb);
    if (o == ST) check("mem_wdata", mem_wdata, wd);
    mem_ready = 1; mem_rdata = rdata;
    #1 check("ready_stall", stall, 0);
    @(negedge CLK);
    mem_ready = 0; ex_valid = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge CLK);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_err", wb_err, 0);
    RST = 0;
    ex_valid = 1; op = ALU; AluOutput = 32'h1234; RegWr = 1; rd = 5;
    @(negedge CLK);
    check("pt_valid", wb_valid, 1);
    check("pt_data", wb_data, 32'h1234);
    check("pt_regwr", wb_RegWr, 1);
    check("pt_rd", wb_rd, 5);
    check("pt_err", wb_err, 0);
    check("pt_mem_req", mem_req, 0);
    ex_valid = 0;
    @(negedge CLK);
    check("idle_valid", wb_valid, 0);
    check("idle_regwr", wb_RegWr, 0);
    mem_op(LD, 3'b000, 32'h103, 0, 2, 32'h80FF_FF7F, 4'b0000, 0);
    check("lb_valid", wb_valid, 1);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_regwr", wb_RegWr, 1);
    check("lb_rd", wb_rd, 9);
    check("lb_mem_req", mem_req, 0);
    mem_op(LD, 3'b100, 32'h103, 0, 1, 32'h80FF_FF7F, 4'b0000, 0);
    check("lbu_data", wb_data, 32'h0000_0080);
    mem_op(LD, 3'b001, 32'h102, 0, 1, 32'h80FF_FF7F, 4'b0000, 0);
    check("lh_data", wb_data, 32'hFFFF_80FF);
    mem_op(LD, 3'b101, 32'h100, 0, 3, 32'h80FF_FF7F, 4'b0000, 0);
    check("lhu_data", wb_data, 32'h0000_FF7F);
    mem_op(LD, 3'b010, 32'h8, 0, 1, 32'hDEAD_BEEF, 4'b0000, 0);
    check("lw_data", wb_data, 32'hDEAD_BEEF);
    mem_op(ST, 3'b001, 32'h202, 32'hABCD_1234, 1, 0, 4'b1100, 32'h1234_1234);
    check("sh_valid", wb_valid, 1);
    check("sh_regwr", wb_RegWr, 0);
    check("sh_data", wb_data, 32'h202);
    check("sh_err", wb_err, 0);
    mem_op(ST, 3'b000, 32'h201, 32'h0000_0055, 1, 0, 4'b0010, 32'h5555_5555);
    mem_op(ST, 3'b010, 32'h204, 32'h0BAD_F00D, 2, 0, 4'b1111, 32'h0BAD_F00D);
    issue(LD, 3'b010, 32'h006, 0);
    ex_valid = 0;
    check("mis_valid", wb_valid, 1);
    check("mis_err", wb_err, 2'b01);
    check("mis_regwr", wb_RegWr, 0);
    check("mis_mem_req", mem_req, 0);
    issue(LD, 3'b001, 32'h101, 0);
    ex_valid = 0;
    check("mis_h_err", wb_err, 2'b01);
    issue(LD, 3'b011, 32'h008, 0);
    ex_valid = 0;
    check("ill_ld_err", wb_err, 2'b11);
    check("ill_ld_req", mem_req, 0);
    issue(ST, 3'b100, 32'h008, 0);
    ex_valid = 0;
    check("ill_st_err", wb_err, 2'b11);
    check("ill_st_regwr", wb_RegWr, 0);
    issue(LD, 3'b010, 32'h10, 0);
    ex_valid = 0;
    n = 0;
    while (stall && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("to_stall_cycles", n, 15);
    check("to_req_held", mem_req, 1);
    @(negedge CLK);
    check("to_req", mem_req, 0);
    check("to_valid", wb_valid, 1);
    check("to_err", wb_err, 2'b10);
    check("to_regwr", wb_RegWr, 0);
    @(negedge CLK);
    check("to_stall_after", stall, 0);
    issue(LD, 3'b010, 32'h14, 0);
    ex_valid = 0;
    n = 0;
    while (stall && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("race_stall_cycles", n, 15);
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    mem_ready = 0;
    check("race_valid", wb_valid, 1);
    check("race_err", wb_err, 0);
    check("race_data", wb_data, 32'hCAFE_F00D);
    check("race_regwr", wb_RegWr, 1);
    issue(LD, 3'b010, 32'h20, 0);
    ex_valid = 0;
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0; mem_ready = 1; mem_rdata = 32'h1111_2222;
    check("rw_req", mem_req, 0);
    check("rw_valid", wb_valid, 0);
    check("rw_data", wb_data, 0);
    check("rw_addr", mem_addr, 0);
    check("rw_stall", stall, 0);
    @(negedge CLK);
    mem_ready = 0;
    check("late_valid", wb_valid, 0);
    check("late_req", mem_req, 0);
    check("late_data", wb_data, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
